mage_agu: RTL

- Affine address generation unit directly downstream of the 4-nested hardware loop unit.
- Consumes loop induction variables when the loop unit flags them valid (once per II window).
- Computes addr = base + sum(stride[i] * iv[i]) in a 2-stage pipeline and buffers results in a small FIFO.
- Drives a valid/ready stream toward the memory port, tagging the final address with last and reporting completion and overflow.

---
 rtl/mage_agu.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mage_agu.sv
// Affine address generator: addr = base + sum(stride[i] * iv[i]), two pipeline
// stages feeding a small output FIFO with last/done/overflow tracking.
module mage_agu #(
  parameter int N_LP        = 4,
  parameter int NBIT_LP_IV  = 8,
  parameter int NBIT_STRIDE = 8,
  parameter int NBIT_ADDR   = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        agu_en_i,
  input  logic                        hwlp_valid_i,
  input  logic [N_LP*NBIT_LP_IV-1:0]  loop_vars_i,
  input  logic [N_LP-1:0]             end_condition_lp_i,
  input  logic [NBIT_ADDR-1:0]        reg_base_i,
  input  logic [N_LP*NBIT_STRIDE-1:0] reg_stride_i,
  output logic [NBIT_ADDR-1:0]        addr_o,
  output logic                        addr_valid_o,
  output logic                        addr_last_o,
  input  logic                        addr_ready_i,
  output logic                        done_o,
  output logic                        overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e state_q, state_d;

  logic                 s1_valid_q, s1_last_q;
  logic [NBIT_ADDR-1:0] p_q [N_LP];
  logic [NBIT_ADDR-1:0] p_d [N_LP];
  logic [NBIT_ADDR-1:0] addr_sum;
  logic                 s1_fire;

  logic [NBIT_ADDR-1:0] mem_addr [FIFO_DEPTH];
  logic                 mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]     wptr_q, rptr_q;
  logic [PTR_W:0]       count_q;
  logic                 empty, full, push_req, push, pop, drop;
  logic                 last_dropped_q;

  assign s1_fire = agu_en_i && hwlp_valid_i && (state_q != DONE);

  // Truncated product of sign-extended stride and zero-extended iv is exact mod 2^NBIT_ADDR
  always_comb begin
    for (int i = 0; i < N_LP; i++) begin
      p_d[i] = {{(NBIT_ADDR-NBIT_STRIDE){reg_stride_i[i*NBIT_STRIDE+NBIT_STRIDE-1]}},
                reg_stride_i[i*NBIT_STRIDE +: NBIT_STRIDE]}
             * {{(NBIT_ADDR-NBIT_LP_IV){1'b0}}, loop_vars_i[i*NBIT_LP_IV +: NBIT_LP_IV]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      for (int i = 0; i < N_LP; i++) p_q[i] <= '0;
    end else if (!agu_en_i) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_fire;
      if (s1_fire) begin
        s1_last_q <= &end_condition_lp_i;
        for (int i = 0; i < N_LP; i++) p_q[i] <= p_d[i];
      end
    end
  end

  always_comb begin
    addr_sum = reg_base_i;
    for (int i = 0; i < N_LP; i++) addr_sum = addr_sum + p_q[i];
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);
  assign push_req = s1_valid_q;
  assign pop      = !empty && addr_ready_i;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk_i) begin
    if (agu_en_i && push) begin
      mem_addr[wptr_q] <= addr_sum;
      mem_last[wptr_q] <= s1_last_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      overflow_o     <= 1'b0;
      last_dropped_q <= 1'b0;
    end else if (!agu_en_i) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      overflow_o     <= 1'b0;
      last_dropped_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
      if (push && !pop)      count_q <= count_q + CNT_ONE;
      else if (pop && !push) count_q <= count_q - CNT_ONE;
      if (drop) overflow_o <= 1'b1;
      if (drop && s1_last_q) last_dropped_q <= 1'b1;
    end
  end

  assign addr_valid_o = !empty;
  assign addr_o       = empty ? '0 : mem_addr[rptr_q];
  assign addr_last_o  = !empty && mem_last[rptr_q];
  assign done_o       = (state_q == DONE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // A dropped final entry can never be popped, so drain completes once everything empties
  always_comb begin
    state_d = state_q;
    if (!agu_en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  state_d = RUN;
        RUN:   if (push_req && s1_last_q) state_d = DRAIN;
        DRAIN: begin
          if (pop && addr_last_o)
            state_d = DONE;
          else if (last_dropped_q && empty && !s1_valid_q)
            state_d = DONE;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
